// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse datapath: controller states, bus register
// offsets and the screen limits used by the position calculator.
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_SETTLE,
    ST_SNAP,
    ST_IRQ
  } mouse_ctrl_state_e;

  localparam logic [2:0] MOUSE_REG_STATUS  = 3'd0;
  localparam logic [2:0] MOUSE_REG_X       = 3'd1;
  localparam logic [2:0] MOUSE_REG_Y       = 3'd2;
  localparam logic [2:0] MOUSE_REG_DX      = 3'd3;
  localparam logic [2:0] MOUSE_REG_DY      = 3'd4;
  localparam logic [2:0] MOUSE_REG_CTRL    = 3'd5;
  localparam logic [2:0] MOUSE_REG_OVERRUN = 3'd6;

  localparam logic [7:0] MOUSE_X_MAX = 8'd159;
  localparam logic [7:0] MOUSE_Y_MAX = 8'd119;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] dx;
    logic [7:0] dy;
  } mouse_snap_t;

endpackage

// File: rtl/mouse_bus_regs.sv
// Bus-facing register file: address decode, control and snapshot registers,
// registered read mux. Optional overrun counter under MOUSE_OVERRUN_CNT_EN.
module mouse_bus_regs
  import mouse_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hA0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_bus_addr,
  input  logic        i_bus_we,
  input  logic [7:0]  i_bus_data_in,
  input  logic        i_snap,
  input  mouse_snap_t i_snap_data,
  input  logic        i_drop,
  output logic        o_irq_en,
  output logic [7:0]  o_bus_data_out,
  output logic        o_bus_data_out_en
);

  logic [7:0]  w_offset;
  logic        w_hit;
  logic        w_rd;
  logic [7:0]  w_rd_mux;
  logic [7:0]  w_overrun;
  mouse_snap_t r_snap;
  logic        r_irq_en;
  logic [7:0]  r_data_out;
  logic        r_data_out_en;

  // Subtracting the base keeps the decode correct for any BASE_ADDR alignment.
  assign w_offset = i_bus_addr - BASE_ADDR;
  assign w_hit    = (w_offset[7:3] == 5'd0);
  assign w_rd     = w_hit && !i_bus_we;

`ifdef MOUSE_OVERRUN_CNT_EN
  logic [7:0] r_overrun;
  logic       w_unused;

  assign w_unused = |i_bus_data_in[7:1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun <= '0;
    end else if (w_hit && i_bus_we && w_offset[2:0] == MOUSE_REG_OVERRUN) begin
      r_overrun <= '0;
    end else if (i_drop && r_overrun != 8'hFF) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign w_overrun = r_overrun;
`else
  logic w_unused;

  assign w_unused  = (|i_bus_data_in[7:1]) | i_drop;
  assign w_overrun = 8'h00;
`endif

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_rd_mux = '0;
    case (w_offset[2:0])
      MOUSE_REG_STATUS:  w_rd_mux = r_snap.status;
      MOUSE_REG_X:       w_rd_mux = r_snap.x;
      MOUSE_REG_Y:       w_rd_mux = r_snap.y;
      MOUSE_REG_DX:      w_rd_mux = r_snap.dx;
      MOUSE_REG_DY:      w_rd_mux = r_snap.dy;
      MOUSE_REG_CTRL:    w_rd_mux = {7'd0, r_irq_en};
      MOUSE_REG_OVERRUN: w_rd_mux = w_overrun;
      default:           w_rd_mux = '0;
    endcase
  end

  // NOTE: the snapshot bank is only five bytes of flops, so it is reset like any other register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_snap        <= '0;
      r_irq_en      <= 1'b1;
      r_data_out    <= '0;
      r_data_out_en <= 1'b0;
    end else begin
      if (i_snap) begin
        r_snap <= i_snap_data;
      end
      if (w_hit && i_bus_we && w_offset[2:0] == MOUSE_REG_CTRL) begin
        r_irq_en <= i_bus_data_in[0];
      end
      r_data_out_en <= w_rd;
      r_data_out    <= w_rd ? w_rd_mux : 8'h00;
    end
  end

  assign o_irq_en          = r_irq_en;
  assign o_bus_data_out    = r_data_out;
  assign o_bus_data_out_en = r_data_out_en;

endmodule

// File: rtl/mouse_bus_ctrl.sv
// Mouse packet sequencer: latch packet, strobe the position calculator, wait
// its settle time, snapshot, interrupt. Optional macro: MOUSE_OVERRUN_CNT_EN.
module mouse_bus_ctrl
  import mouse_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = 8'hA0,
  parameter int         SETTLE_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pkt_valid,
  input  logic [7:0] i_pkt_status,
  input  logic [7:0] i_pkt_dx,
  input  logic [7:0] i_pkt_dy,
  output logic [7:0] o_pos_status,
  output logic [7:0] o_pos_dx,
  output logic [7:0] o_pos_dy,
  output logic       o_pos_update,
  input  logic [7:0] i_mouse_pos_x,
  input  logic [7:0] i_mouse_pos_y,
  input  logic [7:0] i_bus_addr,
  input  logic       i_bus_we,
  input  logic [7:0] i_bus_data_in,
  output logic [7:0] o_bus_data_out,
  output logic       o_bus_data_out_en,
  output logic       o_bus_interrupt_raise,
  input  logic       i_bus_interrupt_ack
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  mouse_ctrl_state_e r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_pos_status;
  logic [7:0]        r_pos_dx;
  logic [7:0]        r_pos_dy;
  logic              r_pos_update;
  logic              r_irq_raise;
  logic              w_irq_en;
  logic              w_snap;
  logic              w_drop;
  mouse_snap_t       w_snap_data;

  assign w_snap = (r_state == ST_SNAP);
  assign w_drop = i_pkt_valid && (r_state != ST_IDLE);

  assign w_snap_data = '{status: r_pos_status, x: i_mouse_pos_x, y: i_mouse_pos_y,
                         dx: r_pos_dx, dy: r_pos_dy};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pos_status <= '0;
      r_pos_dx     <= '0;
      r_pos_dy     <= '0;
      r_pos_update <= 1'b0;
      r_irq_raise  <= 1'b0;
    end else begin
      r_pos_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_pkt_valid) begin
            r_pos_status <= i_pkt_status;
            r_pos_dx     <= i_pkt_dx;
            r_pos_dy     <= i_pkt_dy;
            r_pos_update <= 1'b1;
            r_state      <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          r_cnt   <= SETTLE_LOAD;
          r_state <= (SETTLE_CYCLES == 1) ? ST_SNAP : ST_SETTLE;
        end
        ST_SETTLE: begin
          // Counter reaches zero on the transition into SNAP.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          if (w_irq_en) begin
            r_irq_raise <= 1'b1;
            r_state     <= ST_IRQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_IRQ: begin
          if (i_bus_interrupt_ack || !w_irq_en) begin
            r_irq_raise <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_irq_raise <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  mouse_bus_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_bus_addr        (i_bus_addr),
    .i_bus_we          (i_bus_we),
    .i_bus_data_in     (i_bus_data_in),
    .i_snap            (w_snap),
    .i_snap_data       (w_snap_data),
    .i_drop            (w_drop),
    .o_irq_en          (w_irq_en),
    .o_bus_data_out    (o_bus_data_out),
    .o_bus_data_out_en (o_bus_data_out_en)
  );

  assign o_pos_status          = r_pos_status;
  assign o_pos_dx              = r_pos_dx;
  assign o_pos_dy              = r_pos_dy;
  assign o_pos_update          = r_pos_update;
  assign o_bus_interrupt_raise = r_irq_raise;

endmodule

// File: doc/mouse_bus_ctrl.md
# mouse_bus_ctrl

Sequencer and bus front-end for the mouse datapath. Latches each completed mouse packet and issues a one-cycle update strobe to the position calculator. After the calculator's fixed settle time it snapshots the new position into shadow registers, then raises a processor interrupt held until acknowledged. It sits between the PS/2 mouse transceiver, the position calculator and the microprocessor data bus.

## Interface
- BASE_ADDR, 8'hA0, bus address of register 0; block decodes BASE_ADDR..BASE_ADDR+7
- SETTLE_CYCLES, 3, cycles from POS_UPDATE to position outputs valid; legal range 1..15
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- PKT_VALID  in  1  one-cycle pulse: PKT_STATUS/PKT_DX/PKT_DY hold a complete packet
- PKT_STATUS  in  8  YV, XV, YS, XS, 1, 0, R, L
- PKT_DX / PKT_DY  in  8  raw deltas
- POS_STATUS / POS_DX / POS_DY  out  8  latched packet driven to the position calculator
- POS_UPDATE  out  1  level to the position calculator; one-cycle high pulse per accepted packet
- MOUSE_POS_X / MOUSE_POS_Y  in  8  position calculator outputs
- BUS_ADDR  in  8  processor address
- BUS_WE  in  1  write enable
- BUS_DATA_IN  in  8  write data
- BUS_DATA_OUT  out  8  read data
- BUS_DATA_OUT_EN  out  1  high when BUS_DATA_OUT must drive the shared bus
- BUS_INTERRUPT_RAISE  out  1  interrupt request to the processor
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from the processor

## Operation
- Registers, offsets from BASE_ADDR:
  - 0: status snapshot
  - 1: X snapshot
  - 2: Y snapshot
  - 3: DX snapshot
  - 4: DY snapshot
  - 5: control, R/W; bit0 IRQ_EN (reset 1); other bits read 0
  - 6: overrun count, only with the macro; otherwise reads 0
  - 7: reads 8'h00
- Writes to offsets other than 5 are ignored.
- FSM states: IDLE, STROBE, SETTLE, SNAP, IRQ.
  - IDLE: on PKT_VALID, latch the packet into POS_* and go to STROBE.
  - STROBE: POS_UPDATE=1 for exactly this cycle. Load the settle counter with SETTLE_CYCLES-1. Go to SETTLE.
  - SETTLE: decrement the counter. At 0, go to SNAP.
  - SNAP: copy MOUSE_POS_X/Y, POS_STATUS, POS_DX and POS_DY into the snapshot registers. If IRQ_EN=1, go to IRQ; else go to IDLE.
  - IRQ: BUS_INTERRUPT_RAISE=1. Leave on BUS_INTERRUPT_ACK and go to IDLE.
- PKT_VALID in any state except IDLE: packet dropped. POS_* and snapshot registers are unchanged.
- Clearing IRQ_EN while in IRQ: drop the raise next cycle and return to IDLE.
- ACK outside IRQ: ignored.
- Snapshot registers change only in SNAP. The processor never reads a half-updated position.

## Timing
- Reset values: all POS_* 0; snapshot registers 0; IRQ_EN 1; POS_UPDATE, BUS_INTERRUPT_RAISE, BUS_DATA_OUT_EN 0; BUS_DATA_OUT 0; state IDLE.
- PKT_VALID in cycle n:
  - POS_* valid from cycle n+1.
  - POS_UPDATE high in n+1.
  - SNAP in n+1+SETTLE_CYCLES.
  - BUS_INTERRUPT_RAISE high from n+2+SETTLE_CYCLES.
- ACK in cycle m: RAISE low in m+1; a PKT_VALID in m+1 is accepted.
- Reads are registered. An address in range with BUS_WE=0 in cycle n gives BUS_DATA_OUT and BUS_DATA_OUT_EN=1 in cycle n+1 only. Out-of-range addresses give EN=0.
- A read of a snapshot register in the same cycle as SNAP returns the old value.
- A write to control in cycle n takes effect in n+1.
- RESET mid-sequence aborts to IDLE on the next edge. No POS_UPDATE or RAISE is issued afterwards.

## Configuration
- MOUSE_OVERRUN_CNT_EN defined:
  - 8-bit counter at offset 6 increments on each dropped packet and saturates at 255.
  - Any write to offset 6 clears it.
  - If a drop and a write to offset 6 occur in the same cycle, the clear wins.
- Undefined: no counter logic; offset 6 reads 0.

## Structure
- Shared package mouse_pkg:
  - state enum mouse_ctrl_state_e
  - register offset localparams MOUSE_REG_STATUS … MOUSE_REG_OVERRUN
  - MOUSE_X_MAX/MOUSE_Y_MAX constants shared with the position calculator
- Sub-module: mouse_bus_regs, holding address decode, control/snapshot/overrun registers and registered read mux. The FSM stays in the top.

## Test plan
- Reset, then read offsets 0–7 → 0,0,0,0,0,1,0,0; EN high one cycle after each read.
- PKT_VALID with status 8'h08, DX=5, DY=3; calculator model returns X=5, Y=3 → POS_UPDATE pulses at n+1, RAISE at n+5 with default SETTLE_CYCLES; reads give 08/05/03/05/03.
- Second PKT_VALID while RAISE is high → no POS_UPDATE, snapshots unchanged, overrun reads 1 (macro on) or 0 (off); after ACK a new packet is accepted.
- Write 0 to control, send packet → snapshots update, RAISE never asserts, FSM back to IDLE at n+5.
- Assert RESET during SETTLE → no SNAP; snapshots stay 0; no RAISE.
- Macro on, 300 dropped packets → overrun reads 255; write offset 6 → reads 0.
